fetch_stage: RTL and testbench



---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_stage_if_id_reg.sv | 51 +++++
 rtl/fetch_stage.sv | 153 +++++++++++++++
 tb/tb_fetch_stage.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_e : fetch FSM state encoding
//   NOP_INST      : bubble instruction (addi x0,x0,0)
//   if_id_t       : contents of the IF/ID pipeline register
//   align_word    : clears the byte-offset bits of an address
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port between the fetch stage and instruction memory.
//   req    : single-cycle request pulse (fetch -> memory)
//   addr   : word address, valid while req=1 (fetch -> memory)
//   rvalid : response strobe, 1..N cycles after req (memory -> fetch)
//   rdata  : instruction word, valid with rvalid (memory -> fetch)
// master = fetch stage side, slave = memory side.
interface fetch_stage_if;

  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
//   clk_i, rst_i   : clock, async active-high reset
//   redirect_i     : squash, load a bubble (beats stall_i)
//   stall_i        : hold current contents
//   load_i         : a fetched instruction is delivered this cycle
//   load_data_i    : the delivered instruction
//   if_id_o        : registered IF/ID contents
// A bubble keeps the previous pc/pc4 so decode never sees a stray PC.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   redirect_i,
  input  logic   stall_i,
  input  logic   load_i,
  input  if_id_t load_data_i,
  output if_id_t if_id_o
);

  if_id_t if_id_q;
  if_id_t if_id_d;

  always_comb begin
    if_id_d = if_id_q;
    if (redirect_i) begin
      if_id_d.inst  = NOP_INST;
      if_id_d.valid = 1'b0;
    end else if (stall_i) begin
      if_id_d = if_id_q;
    end else if (load_i) begin
      if_id_d = load_data_i;
    end else begin
      if_id_d.inst  = NOP_INST;
      if_id_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      if_id_q <= '{inst: NOP_INST, pc: 32'h0000_0000, pc4: 32'h0000_0004, valid: 1'b0};
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign if_id_o = if_id_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, fetch FSM, one-entry skid buffer and the
// IF/ID register feeding decode.
//   clk_i, rst_i    : clock, async active-high reset
//   stall_i         : hazard unit asks IF/ID to hold
//   redirect_i      : taken branch/jump from EX
//   redirect_pc_i   : redirect target (byte offset ignored)
//   imem            : instruction-memory port (master side)
//   inst_o, pc_o    : IF/ID instruction and its PC
//   pc4_o           : IF/ID pc_o+4 for link writeback
//   valid_o         : IF/ID holds a real instruction
//
// state | meaning
// FETCH | request for pc_q is on the memory port this cycle
// WAIT  | request outstanding, response for pc_q expected
// HOLD  | response captured in skid buffer, IF/ID stalled
// DRAIN | stale request outstanding, its response will be dropped
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic                redirect_i,
  input  logic [31:0]         redirect_pc_i,
  fetch_stage_if.master       imem,
  output logic [31:0]         inst_o,
  output logic [31:0]         pc_o,
  output logic [31:0]         pc4_o,
  output logic                valid_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_inst_q, buf_inst_d;
  logic [31:0]  buf_pc_q, buf_pc_d;

  logic [31:0]  target;
  logic [31:0]  pc_inc;
  logic [31:0]  buf_pc4;
  logic         deliver;
  if_id_t       deliver_data;
  if_id_t       if_id;

  assign target  = align_word(redirect_pc_i);
  assign pc_inc  = pc_q + 32'd4;
  assign buf_pc4 = buf_pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_inst_d   = buf_inst_q;
    buf_pc_d     = buf_pc_q;
    deliver      = 1'b0;
    deliver_data = '{inst: imem.rdata, pc: pc_q, pc4: pc_inc, valid: 1'b1};

    case (state_q)
      FETCH: begin
        // The request on the port this cycle cannot be withdrawn, so a
        // redirect here still has to wait out its response in DRAIN.
        if (redirect_i) begin
          pc_d    = target;
          state_d = DRAIN;
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (redirect_i) begin
          pc_d    = target;
          state_d = imem.rvalid ? FETCH : DRAIN;
        end else if (imem.rvalid) begin
          if (stall_i) begin
            buf_inst_d = imem.rdata;
            buf_pc_d   = pc_q;
            state_d    = HOLD;
          end else begin
            deliver = 1'b1;
            pc_d    = pc_inc;
            state_d = FETCH;
          end
        end
      end

      HOLD: begin
        if (redirect_i) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall_i) begin
          deliver      = 1'b1;
          deliver_data = '{inst: buf_inst_q, pc: buf_pc_q, pc4: buf_pc4, valid: 1'b1};
          pc_d         = pc_inc;
          state_d      = FETCH;
        end
      end

      DRAIN: begin
        // A redirect landing on the same cycle as the stale response has
        // nothing left to drain; staying in DRAIN would wait forever.
        if (redirect_i) begin
          pc_d    = target;
          state_d = imem.rvalid ? FETCH : DRAIN;
        end else if (imem.rvalid) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      buf_inst_q <= 32'h0000_0000;
      buf_pc_q   <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

  // The FSM sits in FETCH during reset so the first request goes out on
  // the very first cycle after release; rst_i masks it until then.
  assign imem.req  = (state_q == FETCH) && !rst_i;
  assign imem.addr = pc_q;

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .redirect_i  (redirect_i),
    .stall_i     (stall_i),
    .load_i      (deliver),
    .load_data_i (deliver_data),
    .if_id_o     (if_id)
  );

  assign inst_o  = if_id.inst;
  assign pc_o    = if_id.pc;
  assign pc4_o   = if_id.pc4;
  assign valid_o = if_id.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by randomized
// stall/redirect/latency traffic, checked by a PC-order scoreboard.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic [31:0] inst_o, pc_o, pc4_o;
  logic        valid_o;

  fetch_stage_if mif();

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (mif),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .pc4_o         (pc4_o),
    .valid_o       (valid_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int consumed = 0;

  // Program image: odd-multiplier hash, distinct word for every address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: decode must consume instructions in strict PC order
  // starting at the last reset/redirect target.
  logic [31:0] exp_q[$];
  logic [31:0] next_fill;

  task automatic refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back(next_fill);
      next_fill = next_fill + 32'd4;
    end
  endtask

  task automatic flush(input logic [31:0] tgt);
    exp_q.delete();
    next_fill = tgt & 32'hFFFF_FFFC;
    refill();
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect_i    = 1'b1;
    redirect_pc_i = tgt;
    flush(tgt);
  endtask

  // Monitor: an IF/ID instruction is consumed on an edge without stall or
  // redirect.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk_i);
      if (!rst_i && valid_o && !stall_i && !redirect_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: got pc %h expected no instruction", pc_o);
        end else begin
          e = exp_q.pop_front();
          if (pc_o !== e || inst_o !== mem_word(e) || pc4_o !== e + 32'd4) begin
            errors++;
            $display("FAIL if_id_stream: got pc %h inst %h pc4 %h expected pc %h inst %h pc4 %h",
                     pc_o, inst_o, pc4_o, e, mem_word(e), e + 32'd4);
          end
          refill();
        end
        consumed++;
      end
    end
  end

  // Instruction memory: fixed latency chosen per request, reset with rst_i
  // unless mem_ignore_rst models a response landing during reset.
  int          lat = 1;
  bit          mem_ignore_rst = 1'b0;
  int          cnt = 0;
  logic [31:0] pend = 32'h0;
  logic        req_s;
  logic [31:0] addr_s;

  initial begin
    mif.rvalid = 1'b0;
    mif.rdata  = 32'h0;
    forever begin
      @(negedge clk_i);
      req_s  = mif.req;
      addr_s = mif.addr;
      if (req_s) begin
        checks++;
        if (cnt != 0 || addr_s[1:0] != 2'b00) begin
          errors++;
          $display("FAIL imem_protocol: got addr %h with %0d cycles outstanding expected aligned, none outstanding",
                   addr_s, cnt);
        end
      end
      @(posedge clk_i);
      #2;
      mif.rvalid = 1'b0;
      if (rst_i && !mem_ignore_rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            mif.rvalid = 1'b1;
            mif.rdata  = mem_word(pend);
          end
        end
        if (req_s) begin
          pend = addr_s;
          if (lat <= 1) begin
            mif.rvalid = 1'b1;
            mif.rdata  = mem_word(addr_s);
          end else begin
            cnt = lat - 1;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [31:0] t;
    int base;

    flush(32'h0);
    repeat (3) cyc();
    chk("reset_inst", inst_o, 32'h13);
    chk("reset_pc", pc_o, 32'h0);
    chk("reset_pc4", pc4_o, 32'h4);
    chk("reset_valid", {31'b0, valid_o}, 32'h0);
    chk("reset_req", {31'b0, mif.req}, 32'h0);

    // Straight-line fetch, 1-cycle memory.
    rst_i = 1'b0;
    flush(32'h0);
    #1;
    chk("first_req", {31'b0, mif.req}, 32'h1);
    chk("first_addr", mif.addr, 32'h0);
    cyc();
    cyc();
    chk("c2_valid", {31'b0, valid_o}, 32'h1);
    chk("c2_pc", pc_o, 32'h0);
    chk("c2_pc4", pc4_o, 32'h4);
    chk("c2_inst", inst_o, mem_word(32'h0));
    chk("c2_addr", mif.req ? mif.addr : 32'hDEAD_BEEF, 32'h4);
    cyc();
    chk("bubble_valid", {31'b0, valid_o}, 32'h0);
    chk("bubble_keeps_pc", pc_o, 32'h0);
    chk("bubble_inst", inst_o, 32'h13);
    cyc();
    chk("c4_pc", pc_o, 32'h4);
    chk("c4_addr", mif.req ? mif.addr : 32'hDEAD_BEEF, 32'h8);

    // Stall for 3 cycles while the response for PC 8 arrives.
    cyc();
    stall_i = 1'b1;
    cyc();
    chk("stall_frozen_pc", pc_o, 32'h4);
    chk("stall_no_req", {31'b0, mif.req}, 32'h0);
    cyc();
    cyc();
    chk("stall_frozen_pc4", pc4_o, 32'h8);
    chk("stall_frozen_valid", {31'b0, valid_o}, 32'h0);
    stall_i = 1'b0;
    cyc();
    chk("hold_release_pc", pc_o, 32'h8);
    chk("hold_release_inst", inst_o, mem_word(32'h8));
    chk("hold_release_valid", {31'b0, valid_o}, 32'h1);
    chk("resume_addr", mif.req ? mif.addr : 32'hDEAD_BEEF, 32'hC);

    // Redirect to 0x100 in WAIT, latency 3.
    lat = 3;
    cyc();
    do_redirect(32'h100);
    cyc();
    redirect_i = 1'b0;
    chk("redir_bubble_valid", {31'b0, valid_o}, 32'h0);
    chk("redir_bubble_inst", inst_o, 32'h13);
    chk("drain_no_req", {31'b0, mif.req}, 32'h0);
    cyc();
    chk("drain_no_req2", {31'b0, mif.req}, 32'h0);
    cyc();
    chk("redir_addr", mif.req ? mif.addr : 32'hDEAD_BEEF, 32'h100);
    repeat (4) cyc();
    chk("redir_pc", pc_o, 32'h100);
    chk("redir_inst", inst_o, mem_word(32'h100));

    // Redirect and stall together: redirect wins.
    lat = 1;
    stall_i = 1'b1;
    do_redirect(32'h200);
    cyc();
    stall_i = 1'b0;
    redirect_i = 1'b0;
    chk("redir_stall_valid", {31'b0, valid_o}, 32'h0);
    chk("redir_stall_inst", inst_o, 32'h13);
    chk("redir_stall_pc", pc_o, 32'h100);
    cyc();
    chk("redir2_addr", mif.req ? mif.addr : 32'hDEAD_BEEF, 32'h200);

    // PC wrap.
    do_redirect(32'hFFFF_FFFC);
    cyc();
    redirect_i = 1'b0;
    cyc();
    chk("wrap_addr", mif.req ? mif.addr : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    cyc();
    cyc();
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4_o, 32'h0);
    chk("wrap_next_addr", mif.req ? mif.addr : 32'hDEAD_BEEF, 32'h0);

    // Unaligned redirect target.
    do_redirect(32'h103);
    cyc();
    redirect_i = 1'b0;
    cyc();
    chk("unaligned_addr", mif.req ? mif.addr : 32'hDEAD_BEEF, 32'h100);

    // Async reset in the middle of WAIT, response lands during reset.
    lat = 3;
    cyc();
    #2;
    rst_i = 1'b1;
    mem_ignore_rst = 1'b1;
    #1;
    chk("async_rst_pc", pc_o, 32'h0);
    chk("async_rst_pc4", pc4_o, 32'h4);
    chk("async_rst_valid", {31'b0, valid_o}, 32'h0);
    chk("async_rst_req", {31'b0, mif.req}, 32'h0);
    repeat (3) cyc();
    rst_i = 1'b0;
    mem_ignore_rst = 1'b0;
    lat = 2;
    flush(32'h0);
    #1;
    chk("post_rst_addr", mif.req ? mif.addr : 32'hDEAD_BEEF, 32'h0);
    repeat (3) cyc();
    chk("post_rst_pc", pc_o, 32'h0);
    chk("post_rst_inst", inst_o, mem_word(32'h0));
    chk("post_rst_valid", {31'b0, valid_o}, 32'h1);

    // Randomized traffic.
    base = consumed;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      redirect_i = 1'b0;
      stall_i    = ($urandom_range(0, 3) == 0);
      lat        = $urandom_range(1, 4);
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        else t = $urandom;
        do_redirect(t);
      end
    end
    cyc();
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    repeat (20) cyc();

    checks++;
    if (consumed - base < 100) begin
      errors++;
      $display("FAIL random_progress: got %0d instructions expected at least 100", consumed - base);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
